regfile_write_scoreboard: RTL

- Write side of the 16 x 16-bit register file.
- Decodes the write-back register ID into a one-hot write wordline and owns the register storage. Feeds two read ports with write-before-read bypass.
- Keeps a pending-write scoreboard (set at issue, cleared at write-back) so the hazard unit can stall dependent instructions.
- Sits between the decode/issue stage and the write-back stage of the pipeline.

---
 rtl/regfile_write_scoreboard_pkg.sv | 9 +
 rtl/regfile_write_scoreboard_write_decoder.sv | 19 +
 rtl/regfile_write_scoreboard.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_write_scoreboard_pkg.sv
// Shared sizes and types for the write side of the 16 x 16-bit register file.
package regfile_write_scoreboard_pkg;
    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   word_t;
endpackage

// File: rtl/regfile_write_scoreboard_write_decoder.sv
// 4-to-16 one-hot write decoder assembled from 2-to-4 decoders.
module write_decoder_4_16 (
    input  logic        i_en,
    input  logic [3:0]  i_id,
    output logic [15:0] o_onehot
);
    function automatic logic [3:0] dec_2_4(input logic en, input logic [1:0] sel);
        dec_2_4 = en ? (4'b0001 << sel) : 4'b0000;
    endfunction

    logic [3:0] w_grp_en;

    // The upper ID bits pick a group of four rows; the lower bits pick the row.
    assign w_grp_en = dec_2_4(i_en, i_id[3:2]);

    for (genvar g = 0; g < 4; g++) begin : g_row_dec
        assign o_onehot[4*g +: 4] = dec_2_4(w_grp_en[g], i_id[1:0]);
    end
endmodule

// File: rtl/regfile_write_scoreboard.sv
// Register storage, bypassed read ports and pending-write scoreboard.
module regfile_write_scoreboard
    import regfile_write_scoreboard_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [REG_ID_W-1:0] iss_dst,
    input  logic                wb_en,
    input  logic [REG_ID_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic [REG_ID_W-1:0] src1_id,
    input  logic [REG_ID_W-1:0] src2_id,
    output logic [DATA_W-1:0]   src1_data,
    output logic [DATA_W-1:0]   src2_data,
    output logic                src1_busy,
    output logic                src2_busy,
    output logic [NUM_REGS-1:0] write_wordline,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                err_double_issue
);
    localparam logic [NUM_REGS-1:0] ZERO_MASK =
        (ZERO_REG != 0) ? NUM_REGS'(1) : '0;

    word_t               r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic                r_err;

    logic [NUM_REGS-1:0] w_wb_dec;
    logic [NUM_REGS-1:0] w_wordline;
    logic [NUM_REGS-1:0] w_iss_dec;
    logic [NUM_REGS-1:0] w_iss_set;
    logic [NUM_REGS-1:0] w_pending_next;
    logic                w_double_issue;
    logic                w_src1_zero;
    logic                w_src2_zero;
    logic                w_src1_hit;
    logic                w_src2_hit;

    write_decoder_4_16 u_wb_dec (
        .i_en     (wb_en),
        .i_id     (wb_reg),
        .o_onehot (w_wb_dec)
    );

    write_decoder_4_16 u_iss_dec (
        .i_en     (iss_valid),
        .i_id     (iss_dst),
        .o_onehot (w_iss_dec)
    );

    assign w_wordline = w_wb_dec & ~ZERO_MASK;
    assign w_iss_set  = w_iss_dec & ~ZERO_MASK;

    // A fresh issue outranks a same-cycle write-back: a new producer is in flight.
    assign w_pending_next = (r_pending & ~w_wordline) | w_iss_set;

    // Retire-then-reissue of the same register in one cycle is not an error.
    assign w_double_issue = |(w_iss_set & r_pending & ~w_wordline);

    assign w_src1_zero = (ZERO_REG != 0) && (src1_id == '0);
    assign w_src2_zero = (ZERO_REG != 0) && (src2_id == '0);
    assign w_src1_hit  = wb_en && (wb_reg == src1_id);
    assign w_src2_hit  = wb_en && (wb_reg == src2_id);

    always_comb begin
        src1_data = r_regs[src1_id];
        if (w_src1_zero) begin
            src1_data = '0;
        end else if (w_src1_hit) begin
            src1_data = wb_data;
        end
    end

    always_comb begin
        src2_data = r_regs[src2_id];
        if (w_src2_zero) begin
            src2_data = '0;
        end else if (w_src2_hit) begin
            src2_data = wb_data;
        end
    end

    assign src1_busy = r_pending[src1_id] && !w_src1_hit;
    assign src2_busy = r_pending[src2_id] && !w_src2_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wordline[i]) begin
                    r_regs[i] <= wb_data;
                end
            end
            r_pending <= w_pending_next;
            if (w_double_issue) begin
                r_err <= 1'b1;
            end
        end
    end

    assign write_wordline   = w_wordline;
    assign pending_mask     = r_pending;
    assign err_double_issue = r_err;
endmodule
